// File: rtl/dsc_mul_sched.sv
// Round-robin scheduler that shares one serial DSC multiplier between NUM_REQ requesters.
// Optional watchdog on the RUN phase: define DSC_MUL_SCHED_TIMEOUT_EN.
module dsc_mul_sched #(
    parameter int  DATA_WIDTH = 5,
    parameter int  NUM_INPUTS = 2,
    parameter int  NUM_REQ    = 4,
    localparam int RES_WIDTH  = DATA_WIDTH * NUM_INPUTS,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int OPW        = NUM_INPUTS * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_data,
    output logic                   mul_clr,
    output logic                   mul_en,
    output logic [OPW-1:0]         mul_opnd,
    input  logic                   mul_done,
    input  logic [RES_WIDTH-1:0]   mul_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [RES_WIDTH-1:0]   rsp_data,
    output logic                   rsp_err
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_RESP} state_t;

    state_t          state_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] grant_reg;
    logic [ID_W-1:0] rr_ptr_next;

    logic [OPW-1:0]  req_opnd [NUM_REQ];
    logic [ID_W:0]   cand_sum [NUM_REQ];
    logic [ID_W-1:0] cand     [NUM_REQ];
    logic            any_valid;
    logic [ID_W-1:0] pick;

    // cand[k] is the requester k positions after rr_ptr, wrapped into range.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_opnd[gi] = req_data[gi*OPW +: OPW];
        assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
        assign cand[gi]     = (cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                            ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                            : cand_sum[gi][ID_W-1:0];
    end

    // Scan from the farthest candidate down so the nearest asserted one wins.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[cand[k]]) begin
                any_valid = 1'b1;
                pick      = cand[k];
            end
        end
    end

    assign req_ready   = (state_reg == S_IDLE && any_valid && rst)
                       ? (NUM_REQ'(1) << pick) : '0;
    assign rr_ptr_next = (grant_reg == ID_W'(NUM_REQ - 1)) ? '0 : grant_reg + ID_W'(1);

`ifdef DSC_MUL_SCHED_TIMEOUT_EN
    localparam int             WD_W    = RES_WIDTH + 2;
    localparam logic [WD_W-1:0] WD_LAST = (WD_W'(1) << RES_WIDTH) + WD_W'(1);
    logic [WD_W-1:0] wd_reg;
    logic            timeout_reg;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            rr_ptr_reg <= '0;
            grant_reg  <= '0;
            mul_clr    <= 1'b0;
            mul_en     <= 1'b0;
            mul_opnd   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
            rsp_err     <= 1'b0;
`endif
        end else begin
            mul_clr <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_reg <= pick;
                        mul_opnd  <= req_opnd[pick];
                        mul_clr   <= 1'b1;
                        state_reg <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    mul_en    <= 1'b1;
                    state_reg <= S_RUN;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
                    wd_reg      <= '0;
                    timeout_reg <= 1'b0;
`endif
                end
                S_RUN: begin
                    if (mul_done) begin
                        mul_en    <= 1'b0;
                        state_reg <= S_DRAIN;
                    end
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
                    else if (wd_reg == WD_LAST) begin
                        mul_en      <= 1'b0;
                        timeout_reg <= 1'b1;
                        state_reg   <= S_DRAIN;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
`endif
                end
                S_DRAIN: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= grant_reg;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
                    rsp_data  <= timeout_reg ? '0 : mul_result;
                    rsp_err   <= timeout_reg;
`else
                    rsp_data  <= mul_result;
`endif
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        rr_ptr_reg <= rr_ptr_next;
                        state_reg  <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Bench for dsc_mul_sched with an exact-count DSC multiplier model and a phase-timeline reference.
module tb_dsc_mul_sched;
    localparam int DW  = 3;
    localparam int NI  = 2;
    localparam int NR  = 4;
    localparam int RW  = DW * NI;
    localparam int OPW = DW * NI;
`ifdef DSC_MUL_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*OPW-1:0] req_data = '0;
    logic              mul_clr;
    logic              mul_en;
    logic [OPW-1:0]    mul_opnd;
    logic              mul_done;
    logic [RW-1:0]     mul_result;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;

    always #5 clk = ~clk;

    dsc_mul_sched #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .mul_clr(mul_clr), .mul_en(mul_en), .mul_opnd(mul_opnd),
        .mul_done(mul_done), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    // Deterministic DSC multiplier: low counter bits compare against a, high bits against b,
    // so 64 enabled cycles accumulate exactly a*b ones.
    logic [5:0] m_cnt = '0;
    logic [5:0] m_acc = '0;
    logic       tie_done = 1'b0;
    always @(posedge clk) begin
        if (mul_clr) begin
            m_cnt <= '0;
            m_acc <= '0;
        end else if (mul_en) begin
            m_cnt <= m_cnt + 6'd1;
            m_acc <= m_acc + {5'd0, (m_cnt[2:0] < mul_opnd[2:0]) && (m_cnt[5:3] < mul_opnd[5:3])};
        end
    end
    assign mul_done   = !tie_done && mul_en && (m_cnt == 6'd63);
    assign mul_result = m_acc;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int arb_idx(input logic [3:0] v, input int p);
        int i;
        for (int k = 0; k < NR; k++) begin
            i = (p + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Reference: phase = cycles since accept; clear at 1, enable for run_len cycles,
    // one drain cycle, then the response is held until taken.
    int             ph = 0;
    int             m_rr = 0;
    int             m_g = 0;
    int             m_len = 64;
    int             m_pick;
    logic [OPW-1:0] m_ops = '0;
    logic [5:0]     m_prod = '0;
    logic           m_err = 1'b0;
    logic [3:0]     e_rdy;
    logic           e_clr, e_en, e_val;

    always @(negedge clk) begin
        if (!rst) begin
            ph   = 0;
            m_rr = 0;
        end else begin
            if (ph == 0) begin
                m_pick = arb_idx(req_valid, m_rr);
                e_rdy  = (m_pick >= 0) ? 4'(1 << m_pick) : 4'd0;
                e_clr  = 1'b0;
                e_en   = 1'b0;
                e_val  = 1'b0;
            end else begin
                e_rdy  = 4'd0;
                e_clr  = (ph == 1);
                e_en   = (ph >= 2 && ph <= m_len + 1);
                e_val  = (ph >= m_len + 3);
            end
            check("req_ready", 32'(req_ready), 32'(e_rdy));
            check("mul_clr", 32'(mul_clr), 32'(e_clr));
            check("mul_en", 32'(mul_en), 32'(e_en));
            check("rsp_valid", 32'(rsp_valid), 32'(e_val));
            if (ph >= 1) check("mul_opnd", 32'(mul_opnd), 32'(m_ops));
            if (e_val) begin
                check("rsp_id", 32'(rsp_id), 32'(m_g));
                check("rsp_data", 32'(rsp_data), 32'(m_prod));
                check("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (ph == 0) begin
                if (m_pick >= 0) begin
                    m_g    = m_pick;
                    m_ops  = req_data[m_pick*OPW +: OPW];
                    m_len  = (TO_EN && tie_done) ? 66 : 64;
                    m_err  = (m_len == 66);
                    m_prod = m_err ? 6'd0 : 6'({3'd0, m_ops[2:0]} * {3'd0, m_ops[5:3]});
                    ph     = 1;
                end
            end else if (e_val) begin
                if (rsp_ready) begin
                    $display("rsp id=%0d data=%0d err=%0d", m_g, m_prod, m_err);
                    m_rr = (m_g + 1) % NR;
                    ph   = 0;
                end
            end else begin
                ph++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] a, input logic [2:0] b);
        req_data[(r*NI)*DW +: DW]     = a;
        req_data[(r*NI + 1)*DW +: DW] = b;
    endtask

    task automatic wait_valid(input string name, output int n, output int c_clr, output int c_en);
        n = 0; c_clr = 0; c_en = 0;
        while (!rsp_valid && n < 300) begin
            if (mul_clr) c_clr++;
            if (mul_en) c_en++;
            tick();
            n++;
        end
        if (!rsp_valid) begin
            total++;
            bad++;
            $display("FAIL %s: rsp_valid not seen within %0d cycles", name, n);
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int n, c_clr, c_en, got, unstable, pulses, vcnt;
    int ids [5];
    int dats[5];
    int exp_ids [5] = '{0, 1, 2, 3, 0};
    int exp_dats[5] = '{0, 49, 24, 15, 0};

    initial begin
        #100000;
        bad++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_en", 32'(mul_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b1;
        tick();

        // Single request from r2, operands 4 and 6
        set_req(2, 3'd4, 3'd6);
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        wait_valid("t1_wait", n, c_clr, c_en);
        check("t1_latency", 32'(n), 32'd66);
        check("t1_clr_cycles", 32'(c_clr), 32'd1);
        check("t1_en_cycles", 32'(c_en), 32'd64);
        check("t1_id", 32'(rsp_id), 32'd2);
        check("t1_data", 32'(rsp_data), 32'd24);
        check("t1_err", 32'(rsp_err), 32'd0);
        handshake();
        check("t1_valid_drop", 32'(rsp_valid), 32'd0);

        // Reset in the middle of RUN
        set_req(3, 3'd7, 3'd7);
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0000;
        repeat (10) tick();
        rst = 1'b0;
        #1;
        check("mid_rst_mul_en", 32'(mul_en), 32'd0);
        check("mid_rst_mul_clr", 32'(mul_clr), 32'd0);
        check("mid_rst_opnd", 32'(mul_opnd), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // All requesters persistent, consumer always ready
        set_req(0, 3'd0, 3'd7);
        set_req(1, 3'd7, 3'd7);
        set_req(2, 3'd4, 3'd6);
        set_req(3, 3'd3, 3'd5);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 5 && n < 1000) begin
            if (rsp_valid) begin
                ids[got]  = int'(rsp_id);
                dats[got] = int'(rsp_data);
                got++;
                if (got == 5) req_valid = 4'b0000;
            end
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        if (got < 5) begin
            total++;
            bad++;
            $display("FAIL rot_wait: only %0d responses seen", got);
        end
        for (int i = 0; i < got; i++) begin
            check($sformatf("rot_id%0d", i), 32'(ids[i]), 32'(exp_ids[i]));
            check($sformatf("rot_data%0d", i), 32'(dats[i]), 32'(exp_dats[i]));
        end

        // Consumer stalls for 20 cycles while others keep requesting
        req_valid = 4'b1110;
        tick();
        wait_valid("hold_wait", n, c_clr, c_en);
        check("hold_id", 32'(rsp_id), 32'd1);
        check("hold_data", 32'(rsp_data), 32'd49);
        unstable = 0;
        pulses   = 0;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid || rsp_id != 2'd1 || rsp_data != 6'd49) unstable++;
            if (req_ready != 4'd0) pulses++;
            tick();
        end
        check("hold_unstable", 32'(unstable), 32'd0);
        check("hold_ready_pulses", 32'(pulses), 32'd0);
        req_valid = 4'b0000;
        handshake();
        vcnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) vcnt++;
            tick();
        end
        check("hold_one_handshake", 32'(vcnt), 32'd0);

`ifdef DSC_MUL_SCHED_TIMEOUT_EN
        // Multiplier never finishes: watchdog returns an error response
        tie_done = 1'b1;
        set_req(0, 3'd2, 3'd3);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        wait_valid("to_wait", n, c_clr, c_en);
        check("to_en_cycles", 32'(c_en), 32'd66);
        check("to_err", 32'(rsp_err), 32'd1);
        check("to_data", 32'(rsp_data), 32'd0);
        handshake();
        tie_done = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        wait_valid("to_next_wait", n, c_clr, c_en);
        check("to_next_err", 32'(rsp_err), 32'd0);
        check("to_next_data", 32'(rsp_data), 32'd6);
        handshake();
`endif

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
